// File: rtl/uart_ram_pkg.sv
// Shared types for the RAM-to-UART stream reader.
// State encoding, byte type and word/byte sizing helper.
package uart_ram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LATCH,
    SEND,
    DONE
  } state_t;

  typedef logic [7:0] byte_t;

  function automatic int bytes_per_word(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/word_serializer.sv
// Holds one RAM word and hands it to the UART TX path,
// least significant byte first, over a valid/ready handshake.
module word_serializer
  import uart_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] word_in,
  output byte_t                 tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  last_byte_accepted
);

  localparam int BPW = bytes_per_word(DATA_WIDTH);
  localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(BPW - 1);

  logic [DATA_WIDTH-1:0] word_q;
  logic [IW-1:0]         idx_q;
  logic                  valid_q;
  logic                  fire;

  assign fire               = valid_q & tx_ready;
  assign last_byte_accepted = fire & (idx_q == LAST_IDX);
  assign tx_data            = word_q[7:0];
  assign tx_valid           = valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      word_q  <= word_in;
      idx_q   <= '0;
      valid_q <= 1'b1;
    end else if (fire) begin
      word_q <= word_q >> 8;
      idx_q  <= idx_q + 1'b1;
      if (idx_q == LAST_IDX) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ram_stream_reader.sv
// Reads a run of RAM words on one port and streams them
// byte by byte to the UART transmitter.
module ram_stream_reader
  import uart_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_data,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready
);

  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of 8 and at least 8");
  end

  localparam logic [ADDR_WIDTH:0] ONE_WORD = (ADDR_WIDTH+1)'(1);

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   rem_q;
  logic                  ram_en_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  load;
  logic                  last_acc;

  assign load     = (state_q == LATCH);
  assign ram_en   = ram_en_q;
  assign ram_addr = addr_q;
  assign busy     = busy_q;
  assign done     = done_q;

  word_serializer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ser (
    .clk               (clk),
    .rst_n             (rst_n),
    .load              (load),
    .word_in           (ram_data),
    .tx_data           (tx_data),
    .tx_valid          (tx_valid),
    .tx_ready          (tx_ready),
    .last_byte_accepted(last_acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      ram_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (word_count == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              addr_q   <= start_addr;
              rem_q    <= word_count;
              state_q  <= READ;
              ram_en_q <= 1'b1;
              busy_q   <= 1'b1;
            end
          end
        end
        READ: begin
          ram_en_q <= 1'b0;
          state_q  <= LATCH;
        end
        LATCH: begin
          state_q <= SEND;
        end
        SEND: begin
          if (last_acc) begin
            // addr_q wraps naturally at the top of the RAM
            addr_q <= addr_q + 1'b1;
            rem_q  <= rem_q - 1'b1;
            if (rem_q == ONE_WORD) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q  <= READ;
              ram_en_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Scoreboard bench for ram_stream_reader: RAM model,
// byte queue checked on every TX handshake, cycle checks per test.
module tb_ram_stream_reader;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   word_count = '0;
  logic          busy;
  logic          done;
  logic          ram_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b0;

  always #5 clk = ~clk;

  ram_stream_reader #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .start_addr(start_addr),
    .word_count(word_count),
    .busy      (busy),
    .done      (done),
    .ram_en    (ram_en),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready)
  );

  logic [DW-1:0] mem [DEPTH];
  int            rd_cnt [DEPTH];

  always @(posedge clk) begin
    if (ram_en) begin
      ram_data <= mem[ram_addr];
      rd_cnt[ram_addr] = rd_cnt[ram_addr] + 1;
    end
  end

  int         tests_run = 0;
  int         failures = 0;
  int         bytes_seen = 0;
  int         done_seen = 0;
  logic [7:0] exp_q [$];
  logic [7:0] exp_b;
  logic       stall_q = 1'b0;
  logic [7:0] stall_data = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_q = 1'b0;
    end else begin
      if (done) done_seen++;
      if (stall_q) begin
        tests_run++;
        if (tx_valid !== 1'b1 || tx_data !== stall_data) begin
          failures++;
          $display("FAIL hold: valid=%b data=%h, required valid=1 data=%h",
                   tx_valid, tx_data, stall_data);
        end
      end
      if (tx_valid && tx_ready) begin
        bytes_seen++;
        tests_run++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL extra_byte: got %h, none expected", tx_data);
        end else begin
          exp_b = exp_q.pop_front();
          if (tx_data !== exp_b) begin
            failures++;
            $display("FAIL byte: got %h, required %h", tx_data, exp_b);
          end
        end
      end
      stall_q    = tx_valid && !tx_ready;
      stall_data = tx_data;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [AW-1:0] a, input logic [AW:0] n);
    start      = 1'b1;
    start_addr = a;
    word_count = n;
    tick();
    start = 1'b0;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    for (int b = 0; b < DW / 8; b++) exp_q.push_back(w[8*b +: 8]);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    tests_run++;
    if ({busy, done, ram_en, tx_valid} !== 4'b0) begin
      failures++;
      $display("FAIL reset_ctl: busy/done/en/valid=%b, required 0000",
               {busy, done, ram_en, tx_valid});
    end
    tests_run++;
    if (ram_addr !== '0 || tx_data !== '0) begin
      failures++;
      $display("FAIL reset_data: addr=%h data=%h, required 0 0",
               ram_addr, tx_data);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int b0, d0;
    mem[5] = 32'hDDCCBBAA;
    push_word(32'hDDCCBBAA);
    tx_ready = 1'b1;
    b0 = bytes_seen;
    d0 = done_seen;
    do_start(10'd5, 11'd1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      tests_run++;
      if (ram_en !== (k == 1) || busy !== (k >= 1 && k <= 6) ||
          tx_valid !== (k >= 3 && k <= 6) || done !== (k == 7)) begin
        failures++;
        $display("FAIL single_t%0d: en=%b busy=%b valid=%b done=%b", k,
                 ram_en, busy, tx_valid, done);
      end
      if (k == 1) begin
        tests_run++;
        if (ram_addr !== 10'd5) begin
          failures++;
          $display("FAIL single_addr: got %0d, required 5", ram_addr);
        end
      end
      tick();
    end
    tests_run++;
    if (bytes_seen - b0 != 4 || done_seen - d0 != 1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL single_totals: bytes=%0d dones=%0d left=%0d, required 4 1 0",
               bytes_seen - b0, done_seen - d0, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    int b0;
    mem[5] = 32'hDDCCBBAA;
    push_word(32'hDDCCBBAA);
    b0 = bytes_seen;
    tx_ready = 1'b1;
    do_start(10'd5, 11'd1);
    for (int k = 1; k <= 12; k++) begin
      tx_ready = !(k >= 4 && k <= 7);
      @(negedge clk);
      tests_run++;
      if (tx_valid !== (k >= 3 && k <= 10) || busy !== (k <= 10) ||
          done !== (k == 11)) begin
        failures++;
        $display("FAIL bp_t%0d: valid=%b busy=%b done=%b", k,
                 tx_valid, busy, done);
      end
      if (k >= 4 && k <= 8) begin
        tests_run++;
        if (tx_data !== 8'hBB) begin
          failures++;
          $display("FAIL bp_data_t%0d: got %h, required bb", k, tx_data);
        end
      end
      tick();
    end
    tx_ready = 1'b1;
    tests_run++;
    if (bytes_seen - b0 != 4 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL bp_totals: bytes=%0d left=%0d, required 4 0",
               bytes_seen - b0, exp_q.size());
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] addrs [$];
    logic got;
    got = 1'b0;
    mem[1023] = 32'h44332211;
    mem[0]    = 32'h88776655;
    push_word(32'h44332211);
    push_word(32'h88776655);
    tx_ready = 1'b1;
    do_start(10'd1023, 11'd2);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (ram_en) addrs.push_back(ram_addr);
      if (done) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    tick();
    tests_run++;
    if (!got) begin
      failures++;
      $display("FAIL wrap_timeout: done=0, required 1 within 40 cycles");
    end
    tests_run++;
    if (addrs.size() != 2 || addrs[0] !== 10'd1023 || addrs[1] !== 10'd0) begin
      failures++;
      $display("FAIL wrap_addrs: count=%0d, required 1023 then 0",
               addrs.size());
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL wrap_left: %0d bytes unsent, required 0", exp_q.size());
    end
  endtask

  task automatic test_zero_and_ignored();
    int b0, d0;
    logic got;
    logic [DW-1:0] w;
    do_start(10'd3, 11'd0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      tests_run++;
      if (done !== (k == 1) || ram_en !== 1'b0 || tx_valid !== 1'b0 ||
          busy !== 1'b0) begin
        failures++;
        $display("FAIL zero_t%0d: done=%b en=%b valid=%b busy=%b", k,
                 done, ram_en, tx_valid, busy);
      end
      tick();
    end
    for (int i = 10; i < 13; i++) begin
      w = $urandom();
      mem[i] = w;
      push_word(w);
    end
    b0 = bytes_seen;
    d0 = done_seen;
    got = 1'b0;
    tx_ready = 1'b1;
    do_start(10'd10, 11'd3);
    for (int k = 1; k <= 60; k++) begin
      start      = (k == 5);
      start_addr = 10'd100;
      word_count = 11'd5;
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    start      = 1'b1;
    start_addr = 10'd200;
    word_count = 11'd1;
    tick();
    start = 1'b0;
    tests_run++;
    if (!got) begin
      failures++;
      $display("FAIL ign_timeout: done=0, required 1 within 60 cycles");
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests_run++;
      if (busy !== 1'b0 || ram_en !== 1'b0 || tx_valid !== 1'b0) begin
        failures++;
        $display("FAIL ign_done_start: busy=%b en=%b valid=%b, required 000",
                 busy, ram_en, tx_valid);
      end
      tick();
    end
    tests_run++;
    if (bytes_seen - b0 != 12 || done_seen - d0 != 1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL ign_totals: bytes=%0d dones=%0d left=%0d, required 12 1 0",
               bytes_seen - b0, done_seen - d0, exp_q.size());
    end
  endtask

  task automatic test_reset_midrun();
    int d0;
    logic [DW-1:0] w;
    for (int i = 20; i < 24; i++) mem[i] = $urandom();
    push_word(mem[20]);
    w = mem[21];
    exp_q.push_back(w[7:0]);
    d0 = done_seen;
    tx_ready = 1'b1;
    do_start(10'd20, 11'd4);
    repeat (9) tick();
    tests_run++;
    if (tx_valid !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre: valid=%b busy=%b, required 1 1", tx_valid, busy);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({tx_valid, ram_en, busy, done} !== 4'b0 || tx_data !== '0 ||
        ram_addr !== '0) begin
      failures++;
      $display("FAIL rst_async: valid/en/busy/done=%b data=%h addr=%h, required 0",
               {tx_valid, ram_en, busy, done}, tx_data, ram_addr);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    tests_run++;
    if (exp_q.size() != 0 || done_seen != d0) begin
      failures++;
      $display("FAIL rst_abort: left=%0d dones=%0d, required 0 0",
               exp_q.size(), done_seen - d0);
    end
    mem[7] = $urandom();
    push_word(mem[7]);
    do_start(10'd7, 11'd1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      tests_run++;
      if (ram_en !== (k == 1) || tx_valid !== (k >= 3 && k <= 6) ||
          done !== (k == 7) || (k == 1 && ram_addr !== 10'd7)) begin
        failures++;
        $display("FAIL rst_after_t%0d: en=%b addr=%0d valid=%b done=%b", k,
                 ram_en, ram_addr, tx_valid, done);
      end
      tick();
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL rst_after_left: %0d bytes unsent, required 0",
               exp_q.size());
    end
  endtask

  task automatic test_full_depth();
    int b0, d0, bad;
    logic got;
    logic [AW-1:0] a;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]    = $urandom();
      rd_cnt[i] = 0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      a = AW'(300 + i);
      push_word(mem[a]);
    end
    b0  = bytes_seen;
    d0  = done_seen;
    got = 1'b0;
    do_start(10'd300, 11'd1024);
    for (int k = 1; k <= 40000; k++) begin
      tx_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    tick();
    tx_ready = 1'b1;
    tests_run++;
    if (!got) begin
      failures++;
      $display("FAIL full_timeout: done=0, required 1 within 40000 cycles");
    end
    tests_run++;
    if (bytes_seen - b0 != 4096 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL full_bytes: got %0d left=%0d, required 4096 0",
               bytes_seen - b0, exp_q.size());
    end
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (rd_cnt[i] != 1) bad++;
    tests_run++;
    if (bad != 0) begin
      failures++;
      $display("FAIL full_reads: %0d words not read exactly once, required 0",
               bad);
    end
    tests_run++;
    if (ram_addr !== 10'd300) begin
      failures++;
      $display("FAIL full_addr_end: got %0d, required 300", ram_addr);
    end
    repeat (5) tick();
    tests_run++;
    if (done_seen - d0 != 1) begin
      failures++;
      $display("FAIL full_done: %0d pulses, required 1", done_seen - d0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_wrap();
    test_zero_and_ignored();
    test_reset_midrun();
    test_full_depth();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
